// File: rtl/instr_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_feeder_pkg
//  Description : Shared definitions for the instruction feeder.
//                - FSM state encoding (3-bit, explicit values)
//                - Opcode value that carries an immediate word (mvi). The
//                  processor decoder uses the same value.
//                - Halt marker word that stops execution
//                - Helper telling whether a state counts as Busy
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_feeder_pkg;

   typedef logic [2:0] state_t;

   localparam state_t c_st_idle   = 3'd0;
   localparam state_t c_st_fetch  = 3'd1;
   localparam state_t c_st_issue  = 3'd2;
   localparam state_t c_st_imm    = 3'd3;
   localparam state_t c_st_wait   = 3'd4;
   localparam state_t c_st_halted = 3'd5;
   localparam state_t c_st_error  = 3'd6;

   // Opcode field value (word[15:13]) of the move-immediate instruction
   localparam logic [2:0]  c_op_mvi    = 3'b001;
   // Program terminator; never presented to the processor
   localparam logic [15:0] c_halt_word = 16'hFFFF;

   // Busy covers every state in which a program is being executed
   function automatic logic state_is_busy(input state_t s);
      return (s == c_st_fetch) || (s == c_st_issue) ||
             (s == c_st_imm)   || (s == c_st_wait);
   endfunction

endpackage
`default_nettype wire

// File: rtl/feeder_prog_ram.sv
`default_nettype none
// ============================================================================
//  Module      : feeder_prog_ram
//  Description : Program memory of the instruction feeder. Simple dual-port,
//                2**ADDR_W x DATA_W, synchronous write and synchronous read
//                (one cycle read latency). No reset on the array or on the
//                read register so it maps onto a block RAM.
//  Ports       : clk        in   clock
//                i_wr_en    in   write strobe
//                i_wr_addr  in   write address
//                i_wr_data  in   write data
//                i_rd_addr  in   read address (sampled on clk)
//                o_rd_data  out  data read from i_rd_addr of previous cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module feeder_prog_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   localparam int c_depth = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [c_depth];
   logic [DATA_W-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/instr_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_feeder
//  Description : Initiator side of the processor Run/Done handshake. Steps
//                through a small program memory, presents each word on o_din
//                with a one-cycle o_run pulse, follows an mvi with its
//                immediate word, and waits for i_done before moving on.
//                A halt word ends the program; a missing i_done ends it with
//                an error after TIMEOUT cycles.
//  Ports       : clk            in   clock, all state on rising edge
//                rst            in   asynchronous active-high reset
//                i_start        in   begin execution at address 0 (not busy)
//                i_abort        in   return to idle on next edge
//                i_wr_en        in   program load strobe (ignored when busy)
//                i_wr_addr      in   program load address
//                i_wr_data      in   program load data
//                i_done         in   processor completion flag
//                o_din          out  word presented to the processor
//                o_run          out  one-cycle instruction strobe
//                o_busy         out  program executing
//                o_halted       out  program ended on the halt word
//                o_error        out  program ended on a Done timeout
//                o_pc           out  address of the current instruction
//                o_instr_count  out  instructions completed since start
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_feeder
   import instr_feeder_pkg::*;
#(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 5,
   parameter int                TIMEOUT   = 64,
   parameter logic [2:0]        OP_MVI    = c_op_mvi,
   parameter logic [DATA_W-1:0] HALT_WORD = c_halt_word
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_done,
   output logic [DATA_W-1:0] o_din,
   output logic              o_run,
   output logic              o_busy,
   output logic              o_halted,
   output logic              o_error,
   output logic [ADDR_W-1:0] o_pc,
   output logic [15:0]       o_instr_count
);

   // Timeout counter only needs to hold TIMEOUT-1
   localparam int               c_to_w    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 2);

   state_t              r_state;
   state_t              w_next_state;

   logic [DATA_W-1:0]   r_din;
   logic [ADDR_W-1:0]   r_pc;
   logic [15:0]         r_count;
   logic [c_to_w-1:0]   r_to_cnt;
   logic                r_is_mvi;

   logic [ADDR_W-1:0]   w_rd_addr;
   logic [DATA_W-1:0]   w_rd_data;
   logic                w_word_is_halt;
   logic                w_word_is_mvi;
   logic                w_timeout;
   logic [ADDR_W-1:0]   w_pc_step;

   logic                w_run;
   logic                w_load_din;
   logic                w_busy;
   logic                w_halted;
   logic                w_error;

   // ------------------------------------------------------------------------
   // Program memory. FETCH reads mem[pc] so the word is on w_rd_data during
   // ISSUE; ISSUE reads mem[pc+1] so an mvi immediate is there during IMM.
   // Address arithmetic wraps naturally at ADDR_W bits.
   // ------------------------------------------------------------------------
   assign w_rd_addr = (r_state == c_st_issue) ? (r_pc + ADDR_W'(1)) : r_pc;

   feeder_prog_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_prog_ram (
      .clk       (clk),
      .i_wr_en   (i_wr_en & ~w_busy),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

   assign w_word_is_halt = (w_rd_data == HALT_WORD);
   assign w_word_is_mvi  = (w_rd_data[DATA_W-1 -: 3] == OP_MVI);
   assign w_timeout      = (r_to_cnt == c_to_last);
   assign w_pc_step      = r_is_mvi ? ADDR_W'(2) : ADDR_W'(1);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state. Abort overrides everything; Done is only looked at in
   // IMM and WAIT (the processor cannot finish while Run is high).
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      if (i_abort) begin
         w_next_state = c_st_idle;
      end else begin
         case (r_state)
            c_st_idle, c_st_halted, c_st_error: begin
               if (i_start) begin
                  w_next_state = c_st_fetch;
               end
            end
            c_st_fetch: begin
               w_next_state = c_st_issue;
            end
            c_st_issue: begin
               if (w_word_is_halt) begin
                  w_next_state = c_st_halted;
               end else if (w_word_is_mvi) begin
                  w_next_state = c_st_imm;
               end else begin
                  w_next_state = c_st_wait;
               end
            end
            c_st_imm, c_st_wait: begin
               if (i_done) begin
                  w_next_state = c_st_fetch;
               end else if (w_timeout) begin
                  w_next_state = c_st_error;
               end else begin
                  w_next_state = c_st_wait;
               end
            end
            default: begin
               w_next_state = c_st_idle;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM: outputs. Run and the live DIN path come straight from the RAM read
   // register so the word is valid in the same cycle as the Run pulse.
   // Abort suppresses both so DIN freezes and Run stays low.
   // ------------------------------------------------------------------------
   always_comb begin
      w_run      = 1'b0;
      w_load_din = 1'b0;
      w_busy     = state_is_busy(r_state);
      w_halted   = 1'b0;
      w_error    = 1'b0;
      case (r_state)
         c_st_issue: begin
            if (!w_word_is_halt && !i_abort) begin
               w_run      = 1'b1;
               w_load_din = 1'b1;
            end
         end
         c_st_imm: begin
            w_load_din = !i_abort;
         end
         c_st_halted: begin
            w_halted = 1'b1;
         end
         c_st_error: begin
            w_error = 1'b1;
         end
         default: begin
            w_run = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: DIN hold register, Pc, instruction count, timeout counter.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_din    <= '0;
         r_pc     <= '0;
         r_count  <= '0;
         r_to_cnt <= '0;
         r_is_mvi <= 1'b0;
      end else begin
         if (w_load_din) begin
            r_din <= w_rd_data;
         end
         if (!i_abort) begin
            case (r_state)
               c_st_idle, c_st_halted, c_st_error: begin
                  if (i_start) begin
                     r_pc    <= '0;
                     r_count <= '0;
                  end
               end
               c_st_fetch: begin
                  // Cleared here so it reads zero on entry to ISSUE
                  r_to_cnt <= '0;
               end
               c_st_issue: begin
                  r_is_mvi <= w_word_is_mvi;
               end
               c_st_imm, c_st_wait: begin
                  if (i_done) begin
                     r_count <= r_count + 16'd1;
                     r_pc    <= r_pc + w_pc_step;
                  end else begin
                     r_to_cnt <= r_to_cnt + c_to_w'(1);
                  end
               end
               default: begin
                  r_is_mvi <= r_is_mvi;
               end
            endcase
         end
      end
   end

   assign o_din         = w_load_din ? w_rd_data : r_din;
   assign o_run         = w_run;
   assign o_busy        = w_busy;
   assign o_halted      = w_halted;
   assign o_error       = w_error;
   assign o_pc          = r_pc;
   assign o_instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_feeder
//  Description : Self-checking bench for instr_feeder. A behavioural model
//                predicts every output each cycle; directed scenarios add
//                hand-computed literal checks. The bench also plays the
//                processor, answering Run with Done after a chosen delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_feeder;

   localparam int DW    = 16;
   localparam int AW    = 5;
   localparam int TO    = 64;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_start = 1'b0;
   logic          i_abort = 1'b0;
   logic          i_wr_en = 1'b0;
   logic [AW-1:0] i_wr_addr = '0;
   logic [DW-1:0] i_wr_data = '0;
   logic          i_done;
   logic [DW-1:0] o_din;
   logic          o_run;
   logic          o_busy;
   logic          o_halted;
   logic          o_error;
   logic [AW-1:0] o_pc;
   logic [15:0]   o_instr_count;

   always #5 clk = ~clk;

   instr_feeder #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .TIMEOUT   (TO),
      .OP_MVI    (3'b001),
      .HALT_WORD (16'hFFFF)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_abort       (i_abort),
      .i_wr_en       (i_wr_en),
      .i_wr_addr     (i_wr_addr),
      .i_wr_data     (i_wr_data),
      .i_done        (i_done),
      .o_din         (o_din),
      .o_run         (o_run),
      .o_busy        (o_busy),
      .o_halted      (o_halted),
      .o_error       (o_error),
      .o_pc          (o_pc),
      .o_instr_count (o_instr_count)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Processor stand-in: Done one cycle, resp_dly cycles after a Run, or held
   // high permanently with force_done.
   // ------------------------------------------------------------------------
   bit resp_en      = 1'b0;
   int resp_dly     = 1;
   bit force_done   = 1'b0;
   int last_run_cyc = -100;

   initial begin
      i_done = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         i_done = force_done | (resp_en && (cyc == last_run_cyc + resp_dly));
      end
   end

   // ------------------------------------------------------------------------
   // Reference model. Execution is tracked as "cycles until the next word is
   // presented" (to_issue >= 0) or "waiting for Done" (to_issue < 0), with
   // the elapsed wait measured from the Run pulse.
   // ------------------------------------------------------------------------
   logic [15:0] m_mem [DEPTH];
   bit          m_active, m_imm, m_cur_mvi, m_halted, m_error;
   int          m_to_issue, m_waited, m_pc, m_count;
   logic [15:0] m_din;

   always @(negedge clk) begin
      logic [15:0] w;
      logic [15:0] e_din;
      bit          e_run;
      if (rst) begin
         m_active = 0; m_imm = 0; m_cur_mvi = 0; m_halted = 0; m_error = 0;
         m_to_issue = -1; m_waited = 0; m_pc = 0; m_count = 0; m_din = '0;
      end
      w     = m_mem[m_pc];
      e_run = !rst && m_active && (m_to_issue == 0) && (w != 16'hFFFF) && !i_abort;
      e_din = m_din;
      if (e_run)
         e_din = w;
      else if (!rst && m_imm && !i_abort)
         e_din = m_mem[(m_pc + 1) % DEPTH];

      chk("model run",    32'(o_run),         32'(e_run));
      chk("model din",    32'(o_din),         32'(e_din));
      chk("model busy",   32'(o_busy),        32'(m_active));
      chk("model halted", 32'(o_halted),      32'(m_halted));
      chk("model error",  32'(o_error),       32'(m_error));
      chk("model pc",     32'(o_pc),          32'(m_pc));
      chk("model count",  32'(o_instr_count), 32'(m_count));
      if (o_run) last_run_cyc = cyc;

      if (!rst) begin
         if (i_wr_en && !m_active) m_mem[i_wr_addr] = i_wr_data;
         if (i_abort) begin
            m_active = 0; m_imm = 0; m_halted = 0; m_error = 0;
         end else if (!m_active) begin
            if (i_start) begin
               m_active = 1; m_to_issue = 1; m_pc = 0; m_count = 0;
               m_halted = 0; m_error = 0;
            end
         end else if (m_to_issue > 0) begin
            m_to_issue--;
         end else if (m_to_issue == 0) begin
            if (w == 16'hFFFF) begin
               m_active = 0; m_halted = 1;
            end else begin
               m_din = w;
               m_cur_mvi = (w[15:13] == 3'b001);
               m_imm = m_cur_mvi;
               m_to_issue = -1;
               m_waited = 0;
            end
         end else begin
            if (m_imm) m_din = m_mem[(m_pc + 1) % DEPTH];
            m_imm = 0;
            if (i_done) begin
               m_count = (m_count + 1) % 65536;
               m_pc = (m_pc + (m_cur_mvi ? 2 : 1)) % DEPTH;
               m_to_issue = 1;
            end else begin
               m_waited++;
               if (m_waited == TO - 1) begin
                  m_active = 0; m_error = 1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the rising edge)
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic [15:0] d);
      i_wr_en   = 1'b1;
      i_wr_addr = a[AW-1:0];
      i_wr_data = d;
      tick();
      i_wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_not_busy(input string name);
      int n = 0;
      while (o_busy && n < 400) begin
         tick();
         n++;
      end
      chk({name, " busy drop"}, 32'(o_busy), 32'd0);
   endtask

   task automatic wait_count(input string name, input logic [15:0] target);
      int n = 0;
      while (o_instr_count != target && n < 600) begin
         tick();
         n++;
      end
      chk({name, " count reached"}, 32'(o_instr_count), 32'(target));
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) tick();
      chk("rst din",    32'(o_din),         32'h0);
      chk("rst run",    32'(o_run),         32'h0);
      chk("rst busy",   32'(o_busy),        32'h0);
      chk("rst halted", 32'(o_halted),      32'h0);
      chk("rst error",  32'(o_error),       32'h0);
      chk("rst pc",     32'(o_pc),          32'h0);
      chk("rst count",  32'(o_instr_count), 32'h0);
      rst = 1'b0;
      tick();

      // 1: single instruction then halt, Done 3 cycles after Run
      load(0, 16'h1000);
      load(1, 16'hFFFF);
      resp_en = 1'b1; resp_dly = 3;
      pulse_start();
      chk("t1 fetch run", 32'(o_run), 32'd0);
      tick();
      chk("t1 run",    32'(o_run), 32'd1);
      chk("t1 din",    32'(o_din), 32'h1000);
      wait_not_busy("t1");
      chk("t1 halted", 32'(o_halted),      32'd1);
      chk("t1 count",  32'(o_instr_count), 32'd1);
      chk("t1 pc",     32'(o_pc),          32'd1);

      // 2: mvi with Done in the immediate cycle
      load(0, 16'h2000);
      load(1, 16'h00A5);
      load(2, 16'hFFFF);
      resp_dly = 1;
      pulse_start();
      tick();
      chk("t2 run",     32'(o_run), 32'd1);
      chk("t2 din op",  32'(o_din), 32'h2000);
      tick();
      chk("t2 imm run", 32'(o_run),  32'd0);
      chk("t2 imm din", 32'(o_din),  32'h00A5);
      chk("t2 imm busy",32'(o_busy), 32'd1);
      tick();
      chk("t2 pc",      32'(o_pc),          32'd2);
      chk("t2 count",   32'(o_instr_count), 32'd1);
      wait_not_busy("t2");
      chk("t2 halted",  32'(o_halted), 32'd1);

      // 3: no Done -> Error TIMEOUT cycles after Run; Start while busy ignored
      load(0, 16'h1000);
      resp_en = 1'b0;
      pulse_start();
      tick();
      chk("t3 run", 32'(o_run), 32'd1);
      repeat (4) tick();
      pulse_start();
      repeat (TO - 6) tick();
      chk("t3 err early",  32'(o_error), 32'd0);
      chk("t3 busy early", 32'(o_busy),  32'd1);
      tick();
      chk("t3 error", 32'(o_error), 32'd1);
      chk("t3 busy",  32'(o_busy),  32'd0);
      chk("t3 run0",  32'(o_run),   32'd0);

      // 4: full memory of plain words, Pc wraps, then Abort in WAIT
      for (int i = 0; i < DEPTH; i++) load(i, 16'h4000 + 16'(i));
      resp_en = 1'b1; resp_dly = 1;
      pulse_start();
      wait_count("t4", 16'd34);
      chk("t4 pc wrap", 32'(o_pc), 32'd2);
      resp_en = 1'b0;
      tick();
      chk("t4 run", 32'(o_run), 32'd1);
      chk("t4 din", 32'(o_din), 32'h4002);
      tick();
      i_abort = 1'b1;
      #1;
      chk("t4 abort run",  32'(o_run),  32'd0);
      chk("t4 abort busy", 32'(o_busy), 32'd1);
      tick();
      i_abort = 1'b0;
      chk("t4 idle busy",  32'(o_busy),         32'd0);
      chk("t4 idle pc",    32'(o_pc),           32'd2);
      chk("t4 idle count", 32'(o_instr_count),  32'd34);
      chk("t4 idle din",   32'(o_din),          32'h4002);

      // 4b: mvi at the last address takes its immediate from address 0
      load(31, 16'h2000);
      load(0,  16'h00C3);
      resp_en = 1'b1; resp_dly = 1;
      pulse_start();
      wait_count("t4b", 16'd32);
      chk("t4b pc", 32'(o_pc), 32'd1);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("t4b busy", 32'(o_busy), 32'd0);

      // 5: Reset in WAIT, then writes while busy are dropped
      load(0, 16'h1000);
      load(1, 16'h1001);
      load(2, 16'hFFFF);
      resp_en = 1'b0;
      pulse_start();
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("t5 rst din",    32'(o_din),         32'h0);
      chk("t5 rst run",    32'(o_run),         32'h0);
      chk("t5 rst busy",   32'(o_busy),        32'h0);
      chk("t5 rst halted", 32'(o_halted),      32'h0);
      chk("t5 rst error",  32'(o_error),       32'h0);
      chk("t5 rst pc",     32'(o_pc),          32'h0);
      chk("t5 rst count",  32'(o_instr_count), 32'h0);
      tick();
      rst = 1'b0;
      tick();

      force_done = 1'b1;
      pulse_start();
      i_wr_en = 1'b1; i_wr_addr = 5'd1; i_wr_data = 16'hBEEF;
      tick();
      chk("t5 run0 din", 32'(o_din), 32'h1000);
      tick();
      tick();
      i_wr_en = 1'b0;
      tick();
      chk("t5 run1",     32'(o_run), 32'd1);
      chk("t5 run1 din", 32'(o_din), 32'h1001);
      wait_not_busy("t5");
      chk("t5 halted", 32'(o_halted),      32'd1);
      chk("t5 count",  32'(o_instr_count), 32'd2);
      pulse_start();
      repeat (4) tick();
      chk("t5 readback run", 32'(o_run), 32'd1);
      chk("t5 readback din", 32'(o_din), 32'h1001);
      wait_not_busy("t5b");
      force_done = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
